// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed integer divider, one quotient bit per clock.
// Uses a non-restoring shift/subtract loop on operand magnitudes, then fixes
// the remainder and applies signs. Result layout matches the HI/LO registers:
// Y[2*WIDTH-1:WIDTH] = remainder (HI), Y[WIDTH-1:0] = quotient (LO).
// Optional feature macro: DIV_ZERO_FLAG_EN adds the sticky div_by_zero output.
`timescale 1ns/1ps

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   Dividend,
  input  logic [WIDTH-1:0]   Divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Y
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_t;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1),
  // which is representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state,     state_next;
  logic [WIDTH:0]     rem,       rem_next;     // WIDTH+1 bits: MSB is remainder sign
  logic [WIDTH-1:0]   quo,       quo_next;     // dividend magnitude shifting out, quotient in
  logic [WIDTH-1:0]   dvs,       dvs_next;     // divisor magnitude
  logic [WIDTH-1:0]   dvd_raw,   dvd_raw_next; // signed dividend, returned as remainder on /0
  logic               sign_q,    sign_q_next;
  logic               sign_r,    sign_r_next;
  logic               zero_div,  zero_div_next;
  logic [CW-1:0]      count,     count_next;
  logic               busy_next;
  logic               done_next;
  logic [2*WIDTH-1:0] y_next;
`ifdef DIV_ZERO_FLAG_EN
  logic               dz_flag_next;
`endif

  // ---------------------------------------------------------------------------
  // Arithmetic for one non-restoring step and for the final fixup
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     dvs_ext;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH:0]     rem_fixed;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rem_signed;

  // Step/fixup arithmetic shared by the DIVIDE and FIXUP states.
  always_comb begin
    dvs_ext   = {1'b0, dvs};
    // Shift {rem,quo} left by one: the next dividend bit enters the remainder.
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    // Non-negative partial remainder subtracts the divisor, negative adds it back.
    rem_step  = rem[WIDTH] ? (rem_shift + dvs_ext) : (rem_shift - dvs_ext);
    // A negative final remainder is one divisor short of the true value.
    rem_fixed = rem[WIDTH] ? (rem + dvs_ext) : rem;
    // Corrected remainder magnitude is below the divisor, so WIDTH bits hold it.
    rem_mag    = rem_fixed[WIDTH-1:0];
    // Truncating division: quotient sign is the XOR of operand signs and the
    // remainder follows the dividend. Negating 2^(WIDTH-1) wraps to itself,
    // which yields the expected most-negative / -1 result.
    quo_signed = sign_q ? (WIDTH'(0) - quo)     : quo;
    rem_signed = sign_r ? (WIDTH'(0) - rem_mag) : rem_mag;
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_next    = state;
    rem_next      = rem;
    quo_next      = quo;
    dvs_next      = dvs;
    dvd_raw_next  = dvd_raw;
    sign_q_next   = sign_q;
    sign_r_next   = sign_r;
    zero_div_next = zero_div;
    count_next    = count;
    busy_next     = busy;
    done_next     = 1'b0;
    y_next        = Y;
`ifdef DIV_ZERO_FLAG_EN
    dz_flag_next  = div_by_zero;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          // Operands are captured here; later input changes cannot affect the result.
          dvd_raw_next  = Dividend;
          sign_q_next   = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
          sign_r_next   = Dividend[WIDTH-1];
          rem_next      = '0;
          quo_next      = magnitude(Dividend);
          dvs_next      = magnitude(Divisor);
          count_next    = CW'(WIDTH);
          busy_next     = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          dz_flag_next  = 1'b0;
`endif
          if (Divisor == '0) begin
            // Zero divisor skips the iteration loop and completes on the next edge.
            zero_div_next = 1'b1;
            state_next    = FIXUP;
          end else begin
            zero_div_next = 1'b0;
            state_next    = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        rem_next   = rem_step;
        // New quotient bit is 1 when the updated partial remainder is non-negative.
        quo_next   = {quo[WIDTH-2:0], ~rem_step[WIDTH]};
        count_next = count - CW'(1);
        if (count == CW'(1)) begin
          state_next = FIXUP;
        end
      end

      FIXUP: begin
        // start is not looked at here; it is accepted again from the next IDLE cycle.
        if (zero_div) begin
          y_next = {dvd_raw, {WIDTH{1'b1}}};
`ifdef DIV_ZERO_FLAG_EN
          dz_flag_next = 1'b1;
`endif
        end else begin
          rem_next = rem_fixed;
          y_next   = {rem_signed, quo_signed};
        end
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register with synchronous clear; clear abandons any division in flight.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dvd_raw  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_div <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y        <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      quo      <= quo_next;
      dvs      <= dvs_next;
      dvd_raw  <= dvd_raw_next;
      sign_q   <= sign_q_next;
      sign_r   <= sign_r_next;
      zero_div <= zero_div_next;
      count    <= count_next;
      busy     <= busy_next;
      done     <= done_next;
      Y        <= y_next;
`ifdef DIV_ZERO_FLAG_EN
      div_by_zero <= dz_flag_next;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a scoreboard. The stimulus side pushes
// the expected Y, completion edge and divide-by-zero flag when a start is
// accepted; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps

module tb_seq_divider;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           clear;
  logic           start;
  logic [W-1:0]   Dividend;
  logic [W-1:0]   Divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] Y;
`ifdef DIV_ZERO_FLAG_EN
  logic           div_by_zero;
`endif

  seq_divider #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .busy     (busy),
    .done     (done),
    .Y        (Y)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] y;
    int             done_edge;
    bit             dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_pulses = 0;
  bit   mon_en = 1'b0;
  bit   prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (prev_done) check("done_one_cycle", 64'(done), 64'd0);
      if (done === 1'b1) begin
        done_pulses++;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("Y", Y, e.y);
          check("done_edge", 64'(cyc), 64'(e.done_edge));
          check("busy_at_done", 64'(busy), 64'd0);
`ifdef DIV_ZERO_FLAG_EN
          check("div_by_zero_at_done", 64'(div_by_zero), 64'(e.dz));
`endif
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  // Drive start so it is sampled at edge at_edge (0 = next edge). When the
  // start should be accepted, push the expected result and done edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int at_edge,
                       input bit accept, input logic [2*W-1:0] ey, input int lat, input bit edz);
    exp_t e;
    while (cyc < at_edge - 1) begin
      @(posedge clock);
      #1;
    end
    start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(posedge clock);
    #1;
    if (accept) begin
      e.y         = ey;
      e.done_edge = cyc + lat;
      e.dz        = edz;
      sb.push_back(e);
      check("busy_after_start", 64'(busy), 64'd1);
    end
    start    = 1'b0;
    Dividend = 32'hDEADBEEF;
    Divisor  = 32'h00000000;
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] ey, input int lat, input bit edz);
    issue(a, b, 0, 1'b1, ey, lat, edz);
    wait_idle(60);
    repeat (2) @(posedge clock);
    #1;
    check("Y_hold", Y, ey);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_edge;
    int pulses;

    clear    = 1'b1;
    start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_Y", Y, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_div_by_zero", 64'(div_by_zero), 64'd0);
`endif
    clear  = 1'b0;
    mon_en = 1'b1;

    // Sign combinations and the overflow case.
    run(32'd100,      32'd7,        {32'd2,        32'd14},        33, 1'b0);
    run(32'hFFFFFF9C, 32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2},  33, 1'b0);
    run(32'd100,      32'hFFFFFFF9, {32'h00000002, 32'hFFFFFFF2},  33, 1'b0);
    run(32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000},  33, 1'b0);

    // Divide by zero completes one edge after start.
    run(32'd55, 32'd0, {32'd55, 32'hFFFFFFFF}, 1, 1'b1);
`ifdef DIV_ZERO_FLAG_EN
    check("div_by_zero_sticky", 64'(div_by_zero), 64'd1);
`endif
    issue(32'hFFFFFF9C, 32'hFFFFFFF9, 0, 1'b1, {32'hFFFFFFFE, 32'h0000000E}, 33, 1'b0);
`ifdef DIV_ZERO_FLAG_EN
    check("div_by_zero_cleared_by_start", 64'(div_by_zero), 64'd0);
`endif
    wait_idle(60);

    // start while busy is ignored and not queued.
    issue(32'd100, 32'd7, 0, 1'b1, {32'd2, 32'd14}, 33, 1'b0);
    a_edge = cyc;
    issue(32'd9, 32'd3, a_edge + 5, 1'b0, '0, 0, 1'b0);
    wait_idle(60);
    run(32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

    // start on the FIXUP edge is ignored; the first IDLE cycle accepts it.
    issue(32'd7, 32'd2, 0, 1'b1, {32'd1, 32'd3}, 33, 1'b0);
    a_edge = cyc;
    issue(32'd9, 32'd3, a_edge + 33, 1'b0, '0, 0, 1'b0);
    issue(32'd9, 32'd3, a_edge + 34, 1'b1, {32'd0, 32'd3}, 33, 1'b0);
    wait_idle(80);

    // clear mid-operation abandons the division with no done pulse.
    issue(32'd100, 32'd7, 0, 1'b1, {32'd2, 32'd14}, 33, 1'b0);
    a_edge = cyc;
    while (cyc < a_edge + 9) begin
      @(posedge clock);
      #1;
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_Y", Y, 64'd0);
    check("clear_done", 64'(done), 64'd0);
    clear  = 1'b0;
    pulses = done_pulses;
    repeat (40) @(posedge clock);
    #1;
    check("no_done_after_clear", 64'(done_pulses - pulses), 64'd0);
    run(32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
